// File: rtl/match_ctrl.sv
// Match-level sequencer: start detection, serve pauses between rallies,
// winner declaration and game-over display flashing, advanced by a game tick.
module match_ctrl #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 1000,
  parameter int FLASH_TICKS = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] score_p1,
  input  logic [3:0] score_p2,
  output logic       run,
  output logic       serve_p,
  output logic       clear_scores,
  output logic [1:0] winner,
  output logic       blank,
  output logic [1:0] state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [3:0]  WIN_LVL    = 4'(WIN_SCORE);
  localparam logic [15:0] SERVE_LAST = 16'(SERVE_TICKS - 1);
  localparam logic [15:0] FLASH_LAST = 16'(FLASH_TICKS - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        start_q;
  logic [3:0]  p1_q, p2_q;
  logic        run_q, run_d;
  logic        serve_q, serve_d;
  logic        clear_q, clear_d;
  logic [1:0]  winner_q, winner_d;
  logic        blank_q, blank_d;

  logic start_rise, p1_pt, p2_pt, w1, w2;

  // Points are score edges seen against last cycle's sample; only PLAY acts on them.
  assign start_rise = start & ~start_q;
  assign p1_pt      = (score_p1 != p1_q);
  assign p2_pt      = (score_p2 != p2_q);
  assign w1         = (score_p1 >= WIN_LVL);
  assign w2         = (score_p2 >= WIN_LVL);

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    serve_d  = serve_q;
    clear_d  = 1'b0;
    winner_d = winner_q;
    blank_d  = blank_q;

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          clear_d  = 1'b1;
          winner_d = 2'b00;
          serve_d  = 1'b0;
          state_d  = S_SERVE;
        end
      end
      S_SERVE: begin
        if (tick) begin
          if (cnt_q == SERVE_LAST) state_d = S_PLAY;
          else                     cnt_d   = cnt_q + 16'd1;
        end
      end
      S_PLAY: begin
        if (p1_pt | p2_pt) begin
          if (w1 | w2) begin
            winner_d = {w2, w1};
            state_d  = S_OVER;
          end else begin
            // The player who conceded serves; a double point falls back to player 1.
            serve_d = p1_pt & ~p2_pt;
            state_d = S_SERVE;
          end
        end
      end
      S_OVER: begin
        if (start_rise) begin
          blank_d  = 1'b0;
          clear_d  = 1'b1;
          winner_d = 2'b00;
          serve_d  = 1'b0;
          state_d  = S_SERVE;
        end else if (tick) begin
          if (cnt_q == FLASH_LAST) begin
            blank_d = ~blank_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    run_d = (state_d == S_PLAY);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      start_q  <= 1'b1;
      p1_q     <= '0;
      p2_q     <= '0;
      run_q    <= 1'b0;
      serve_q  <= 1'b0;
      clear_q  <= 1'b0;
      winner_q <= 2'b00;
      blank_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_q  <= start;
      p1_q     <= score_p1;
      p2_q     <= score_p2;
      run_q    <= run_d;
      serve_q  <= serve_d;
      clear_q  <= clear_d;
      winner_q <= winner_d;
      blank_q  <= blank_d;
    end
  end

  assign run          = run_q;
  assign serve_p      = serve_q;
  assign clear_scores = clear_q;
  assign winner       = winner_q;
  assign blank        = blank_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: directed vector table, a coincident tick/start sequence,
// then randomized play checked against a tick-countdown reference model.
module tb_match_ctrl;

  localparam int WIN = 3;
  localparam int SRV = 4;
  localparam int FLS = 2;

  logic       clk = 1'b0;
  logic       reset, tick, start;
  logic [3:0] score_p1, score_p2;
  logic       run, serve_p, clear_scores, blank;
  logic [1:0] winner, state_o;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  match_ctrl #(.WIN_SCORE(WIN), .SERVE_TICKS(SRV), .FLASH_TICKS(FLS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .score_p1(score_p1), .score_p2(score_p2),
    .run(run), .serve_p(serve_p), .clear_scores(clear_scores),
    .winner(winner), .blank(blank), .state_o(state_o)
  );

  typedef struct {
    logic       rst;
    logic       st_in;
    logic [3:0] s1;
    logic [3:0] s2;
    int         nt;      // tick strobes to apply (0 = one plain cycle)
    logic [1:0] st;
    logic       run;
    logic       srv;
    logic       clr;
    logic [1:0] win;
    logic       blk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rst, int st_in, int s1, int s2, int nt,
                              int st, int rn, int srv, int clr, int win, int blk);
    vec_t v;
    v.rst = 1'(rst);  v.st_in = 1'(st_in); v.s1 = 4'(s1); v.s2 = 4'(s2);
    v.nt  = nt;       v.st = 2'(st);       v.run = 1'(rn); v.srv = 1'(srv);
    v.clr = 1'(clr);  v.win = 2'(win);     v.blk = 1'(blk);
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic rn,
                            input logic srv, input logic clr, input logic [1:0] win,
                            input logic blk);
    check({tag, ".state"},  16'(state_o),      16'(st));
    check({tag, ".run"},    16'(run),          16'(rn));
    check({tag, ".serve"},  16'(serve_p),      16'(srv));
    check({tag, ".clear"},  16'(clear_scores), 16'(clr));
    check({tag, ".winner"}, 16'(winner),       16'(win));
    check({tag, ".blank"},  16'(blank),        16'(blk));
  endtask

  task automatic cyc(input logic tk);
    tick = tk;
    @(posedge clk);
    #1;
  endtask

  // One tick strobe every 4th cycle.
  task automatic apply_ticks(input int n);
    if (n == 0) cyc(1'b0);
    else repeat (n) begin
      repeat (3) cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  // Reference model: phase number plus ticks-remaining countdowns.
  int         m_mode;
  int         m_left;
  logic       m_blank, m_serve, m_clear, m_pstart;
  logic [1:0] m_win;
  logic [3:0] m_p1, m_p2;

  task automatic model_step();
    logic rise, pt1, pt2, w1, w2;
    rise = start && !m_pstart;
    pt1  = (score_p1 != m_p1);
    pt2  = (score_p2 != m_p2);
    m_clear = 1'b0;
    if (reset) begin
      m_mode = 0; m_left = 0; m_blank = 1'b0; m_serve = 1'b0; m_win = 2'b00;
      m_pstart = 1'b1; m_p1 = 4'd0; m_p2 = 4'd0;
      return;
    end
    case (m_mode)
      0: if (rise) begin
        m_clear = 1'b1; m_win = 2'b00; m_serve = 1'b0; m_mode = 1; m_left = SRV;
      end
      1: if (tick) begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end
      2: if (pt1 || pt2) begin
        w1 = (int'(score_p1) >= WIN);
        w2 = (int'(score_p2) >= WIN);
        if (w1 || w2) begin
          m_win = {w2, w1}; m_mode = 3; m_left = FLS;
        end else begin
          m_serve = pt1 && !pt2; m_mode = 1; m_left = SRV;
        end
      end
      default: begin
        if (rise) begin
          m_clear = 1'b1; m_win = 2'b00; m_serve = 1'b0; m_blank = 1'b0;
          m_mode = 1; m_left = SRV;
        end else if (tick) begin
          m_left--;
          if (m_left == 0) begin
            m_blank = !m_blank;
            m_left  = FLS;
          end
        end
      end
    endcase
    m_pstart = start;
    m_p1 = score_p1;
    m_p2 = score_p2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b1; tick = 1'b0; score_p1 = '0; score_p2 = '0;

    //             rst st  s1 s2 nt  state run srv clr win blk
    vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));  // reset, start held
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));  // still held: no rise
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0));  // press: clear pulse
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0));  // pulse is one cycle
    vecs.push_back(mk(0, 0, 0, 0, 3,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  2, 1, 0, 0, 0, 0));  // 4th tick -> PLAY
    vecs.push_back(mk(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0));  // p2 point
    vecs.push_back(mk(0, 0, 0, 1, 3,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1,  2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0,  1, 0, 1, 0, 0, 0));  // p1 point: p2 serves
    vecs.push_back(mk(0, 0, 1, 1, 4,  2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 1, 0,  3, 0, 1, 0, 1, 0));  // p1 reaches WIN
    vecs.push_back(mk(0, 0, 3, 1, 1,  3, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3, 1, 1,  3, 0, 1, 0, 1, 1));  // blank on 2nd tick
    vecs.push_back(mk(0, 0, 3, 1, 2,  3, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3, 1, 2,  3, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 3, 1, 0,  1, 0, 0, 1, 0, 0));  // new match from OVER
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0));  // scores cleared
    vecs.push_back(mk(0, 0, 0, 0, 4,  2, 1, 0, 0, 0, 0));  // no spurious point
    vecs.push_back(mk(0, 0, 2, 2, 0,  1, 0, 0, 0, 0, 0));  // double point, no win
    vecs.push_back(mk(0, 0, 2, 2, 4,  2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 3, 0,  3, 0, 0, 0, 3, 0));  // draw
    vecs.push_back(mk(0, 0, 3, 3, 1,  3, 0, 0, 0, 3, 0));
    vecs.push_back(mk(1, 0, 3, 3, 0,  0, 0, 0, 0, 0, 0));  // reset in OVER
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));  // reset in SERVE
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));  // held through reset

    foreach (vecs[i]) begin
      reset = vecs[i].rst; start = vecs[i].st_in;
      score_p1 = vecs[i].s1; score_p2 = vecs[i].s2;
      apply_ticks(vecs[i].nt);
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].run, vecs[i].srv,
                 vecs[i].clr, vecs[i].win, vecs[i].blk);
    end

    // Tick coinciding with a start press in OVER: the press wins.
    start = 1'b0; cyc(1'b0);
    start = 1'b1; cyc(1'b0);
    check_outs("seq.press", 2'd1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    apply_ticks(SRV);
    check("seq.play", 16'(state_o), 16'd2);
    score_p1 = 4'd3; cyc(1'b0);
    check_outs("seq.over", 2'd3, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    start = 1'b0; apply_ticks(1);
    repeat (3) cyc(1'b0);
    start = 1'b1; cyc(1'b1);
    check_outs("seq.tick_start", 2'd1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    cyc(1'b0);
    check("seq.clear_off", 16'(clear_scores), 16'd0);

    // Randomized play against the reference model.
    reset = 1'b1; tick = 1'b0; score_p1 = '0; score_p2 = '0;
    model_step();
    @(posedge clk); #1;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) start = ~start;
      tick = ((c % 4) == 3);
      if (m_clear) begin
        score_p1 = '0; score_p2 = '0;
      end else if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 2))
          0:       if (score_p1 != 4'hF) score_p1++;
          1:       if (score_p2 != 4'hF) score_p2++;
          default: begin
            if (score_p1 != 4'hF) score_p1++;
            if (score_p2 != 4'hF) score_p2++;
          end
        endcase
      end
      model_step();
      @(posedge clk); #1;
      check_outs($sformatf("rnd%0d", c), 2'(m_mode), (m_mode == 2), m_serve,
                 m_clear, m_win, m_blank);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/match_ctrl.md
Name: match_ctrl

Overview:
Match-level sequencer sitting directly downstream of the game engine's score outputs and upstream of its run/serve control and the display blanking. Detects start presses and points scored, inserts a timed serve pause between rallies, declares the winner at WIN_SCORE, and flashes the displays until a new match is started. Clocked by the game clock domain and advanced by a one-cycle game tick strobe.

Parameters:
WIN_SCORE, 9, score (0-15) at or above which a player wins the match
SERVE_TICKS, 1000, tick strobes spent in SERVE before play resumes (must be >=1)
FLASH_TICKS, 250, tick strobes per half-period of the game-over blank toggle (must be >=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tick  input  1  one-cycle game-rate strobe (~1 kHz)
start  input  1  debounced start button, level
score_p1  input  4  player 1 score from game engine
score_p2  input  4  player 2 score from game engine
run  output  1  high only in PLAY; game engine moves the ball only when high
serve_p  output  1  side to serve: 0 = player 1, 1 = player 2
clear_scores  output  1  one-cycle pulse asking game engine to zero both scores
winner  output  2  00 none, 01 player 1, 10 player 2, 11 draw
blank  output  1  display blank request (flash in OVER)
state_o  output  2  current state: 0 IDLE, 1 SERVE, 2 PLAY, 3 OVER

Behaviour:
Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE, run 0, serve_p 0, clear_scores 0, winner 00, blank 0, tick counter 0, prev-score registers 0, start_q 1.
- start_q resets to 1, so start held through reset must be released and pressed again.
- Reset asserted mid-operation returns to IDLE at the next edge regardless of state.
- start_rise = start & ~start_q; start_q samples start every cycle.
- p1_q/p2_q sample score_p1/score_p2 every cycle in all states. p1_pt = (score_p1 != p1_q), p2_pt likewise.
- 16-bit tick counter; counts only on tick; cleared on every state change.
- All outputs are registered; each transition takes effect the cycle after its qualifying input.
State machine:
- IDLE: run 0, blank 0. On start_rise: clear_scores pulses 1 for exactly one cycle, winner <= 00, serve_p <= 0, go SERVE.
- SERVE: run 0. On tick with counter == SERVE_TICKS-1: go PLAY. Other ticks increment counter.
- PLAY: run 1. If p1_pt or p2_pt:
  - Compute w1 = score_p1 >= WIN_SCORE, w2 = score_p2 >= WIN_SCORE.
  - If w1|w2: winner <= {w2,w1}, go OVER.
  - Else go SERVE with serve_p <= 1 if p1_pt, else 0 (conceding player serves). Both points in the same cycle: serve_p <= 0.
  - start_rise in PLAY is ignored.
- OVER: run 0. winner held. blank toggles on every FLASH_TICKS-th tick (counter wraps to 0 at toggle).
  - On start_rise: blank <= 0, clear_scores pulse, winner <= 00, serve_p <= 0, go SERVE.
- Score changes outside PLAY (including the clear caused by clear_scores) update p1_q/p2_q only; they never count as points.
- tick and start_rise coincident in OVER: start_rise wins. Counter never exceeds 16 bits; parameters above 65535 are illegal.

Test Plan:
(WIN_SCORE=3, SERVE_TICKS=4, FLASH_TICKS=2, tick every 4th cycle)
- Reset, start high through reset, release, press -> no transition while held; clear_scores one-cycle pulse on the press, state_o 1; run 1 exactly on the 4th tick.
- In PLAY, score_p2 0->1 -> next cycle state_o 1, run 0, serve_p 0, winner 00; run 1 again after 4 more ticks.
- score_p1 steps to 3 in PLAY -> winner 01, state_o 3, run 0; blank toggles 0->1->0 every 2 ticks.
- Both scores step from 2 to 3 in the same cycle -> winner 11, state OVER, serve_p 0.
- In OVER with blank 1, press start -> clear_scores pulse, blank 0, winner 00, state SERVE; scores forced to 0 cause no spurious point.
- Assert reset in SERVE mid-count and in OVER -> state_o 0, all outputs at reset values next cycle.
